// File: rtl/dac_sample_capture.sv
// Capture buffer for the filter's DAC output. It records DEPTH samples, one per dac_clk
// rising edge, then streams them out over valid/ready with one registered RAM read per beat.
module dac_sample_capture #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 2000,
    parameter int ADDR_W = 11
) (
    input  logic              sys_clk,
    input  logic              rst,
    input  logic              start,
    input  logic              dac_clk,
    input  logic [DATA_W-1:0] data_in,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   sample_cnt,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              m_last
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CAPTURE,
        ST_FETCH,
        ST_DRAIN,
        ST_DONE
    } state_t;

    state_t              state_reg, state_next;
    logic [ADDR_W-1:0]   wr_ptr_reg, wr_ptr_next;
    logic [ADDR_W-1:0]   rd_ptr_reg, rd_ptr_next;
    logic [ADDR_W:0]     cnt_reg, cnt_next;
    logic                m_valid_reg, m_valid_next;
    logic                dac_clk_q;
    logic                dac_edge;
    logic                wr_en;
    logic                rd_en;
    logic [DATA_W-1:0]   m_data_reg;
    logic [DATA_W-1:0]   mem [DEPTH];

    assign dac_edge = dac_clk & ~dac_clk_q;

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state_reg   <= ST_IDLE;
            wr_ptr_reg  <= '0;
            rd_ptr_reg  <= '0;
            cnt_reg     <= '0;
            m_valid_reg <= 1'b0;
            dac_clk_q   <= 1'b0;
        end else begin
            state_reg   <= state_next;
            wr_ptr_reg  <= wr_ptr_next;
            rd_ptr_reg  <= rd_ptr_next;
            cnt_reg     <= cnt_next;
            m_valid_reg <= m_valid_next;
            dac_clk_q   <= dac_clk;
        end
    end

    // Sample storage is never cleared; every run rewrites all DEPTH entries before readout.
    always_ff @(posedge sys_clk) begin
        if (wr_en) begin
            mem[wr_ptr_reg] <= data_in;
        end
    end

    // The RAM output register doubles as m_data, so it holds steady while DRAIN stalls.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            m_data_reg <= '0;
        end else if (rd_en) begin
            m_data_reg <= mem[rd_ptr_reg];
        end
    end

    always_comb begin
        state_next   = state_reg;
        wr_ptr_next  = wr_ptr_reg;
        rd_ptr_next  = rd_ptr_reg;
        cnt_next     = cnt_reg;
        m_valid_next = m_valid_reg;
        wr_en        = 1'b0;
        rd_en        = 1'b0;
        case (state_reg)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_next  = ST_CAPTURE;
                    wr_ptr_next = '0;
                    rd_ptr_next = '0;
                    cnt_next    = '0;
                end
            end
            ST_CAPTURE: begin
                if (dac_edge) begin
                    wr_en    = 1'b1;
                    cnt_next = cnt_reg + 1'b1;
                    if (wr_ptr_reg == LAST_IDX) begin
                        state_next  = ST_FETCH;
                        rd_ptr_next = '0;
                    end else begin
                        wr_ptr_next = wr_ptr_reg + 1'b1;
                    end
                end
            end
            ST_FETCH: begin
                rd_en        = 1'b1;
                m_valid_next = 1'b1;
                state_next   = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (m_valid_reg && m_ready) begin
                    m_valid_next = 1'b0;
                    if (rd_ptr_reg == LAST_IDX) begin
                        state_next = ST_DONE;
                    end else begin
                        rd_ptr_next = rd_ptr_reg + 1'b1;
                        state_next  = ST_FETCH;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign busy       = (state_reg == ST_CAPTURE) || (state_reg == ST_FETCH) ||
                        (state_reg == ST_DRAIN);
    assign done       = (state_reg == ST_DONE);
    assign sample_cnt = cnt_reg;
    assign m_data     = m_data_reg;
    assign m_valid    = m_valid_reg;
    assign m_last     = m_valid_reg && (rd_ptr_reg == LAST_IDX);

endmodule

// File: tb/tb_dac_sample_capture.sv
// Directed bench for dac_sample_capture at DEPTH=8. It covers capture, readout with and
// without backpressure, ignored starts, re-arm, mid-run reset and dac_clk edge corner cases.
module tb_dac_sample_capture;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 8;
    localparam int ADDR_W = 3;

    logic              sys_clk = 1'b0;
    logic              rst     = 1'b1;
    logic              start   = 1'b0;
    logic              dac_clk = 1'b0;
    logic [DATA_W-1:0] data_in = '0;
    logic              busy;
    logic              done;
    logic [ADDR_W:0]   sample_cnt;
    logic [DATA_W-1:0] m_data;
    logic              m_valid;
    logic              m_ready = 1'b0;
    logic              m_last;

    int checks = 0;
    int errors = 0;

    dac_sample_capture #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .sys_clk   (sys_clk),
        .rst       (rst),
        .start     (start),
        .dac_clk   (dac_clk),
        .data_in   (data_in),
        .busy      (busy),
        .done      (done),
        .sample_cnt(sample_cnt),
        .m_data    (m_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_last    (m_last)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
        $display("check %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    // n dac_clk periods (10 high, 10 low) carrying base, base+1, ...
    // A start pulse is injected during period start_at (-1 for none).
    task automatic capture(input int base, input int n, input int cnt0, input int start_at);
        for (int k = 0; k < n; k++) begin
            data_in = DATA_W'(base + k);
            dac_clk = 1'b1;
            for (int c = 0; c < 10; c++) begin
                start = (k == start_at) && (c == 1);
                tick();
            end
            start   = 1'b0;
            dac_clk = 1'b0;
            repeat (10) tick();
            chk("cap_cnt", 32'(sample_cnt), 32'(cnt0 + k + 1));
        end
    endtask

    // Reads DEPTH beats and expects base+i on beat i. Each beat is stalled for 'stall' cycles.
    // A start pulse is injected on the first stall cycle of beat start_beat.
    task automatic drain(input int base, input int stall, input int start_beat);
        logic [DATA_W-1:0] held;
        m_ready = (stall == 0);
        for (int i = 0; i < DEPTH; i++) begin
            int n = 0;
            while (m_valid !== 1'b1 && n < 40) begin
                tick();
                n++;
            end
            chk("rd_valid", 32'(m_valid), 32'd1);
            chk("rd_data", 32'(m_data), 32'(base + i));
            chk("rd_last", 32'(m_last), 32'(i == DEPTH - 1));
            held = m_data;
            for (int s = 0; s < stall; s++) begin
                m_ready = 1'b0;
                start   = (i == start_beat) && (s == 0);
                tick();
                start = 1'b0;
                chk("stall_data", 32'(m_data), 32'(held));
                chk("stall_valid", 32'(m_valid), 32'd1);
            end
            m_ready = 1'b1;
            tick();
            m_ready = (stall == 0);
            chk("acc_valid", 32'(m_valid), 32'd0);
        end
        m_ready = 1'b0;
        chk("end_done", 32'(done), 32'd1);
        chk("end_busy", 32'(busy), 32'd0);
        chk("end_cnt", 32'(sample_cnt), 32'(DEPTH));
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("arm_busy", 32'(busy), 32'd1);
        chk("arm_done", 32'(done), 32'd0);
        chk("arm_cnt", 32'(sample_cnt), 32'd0);
    endtask

    initial begin
        // Reset for 3 cycles, then idle with dac_clk toggling.
        repeat (3) tick();
        rst = 1'b0;
        for (int c = 0; c < 20; c++) begin
            dac_clk = ((c / 5) % 2) == 1;
            data_in = 8'(c);
            tick();
        end
        dac_clk = 1'b0;
        tick();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_cnt", 32'(sample_cnt), 32'd0);
        chk("rst_mdata", 32'(m_data), 32'd0);
        chk("rst_mvalid", 32'(m_valid), 32'd0);
        chk("rst_mlast", 32'(m_last), 32'd0);

        // Basic ramp with m_ready held high.
        pulse_start();
        capture(0, DEPTH, 0, -1);
        chk("cap_busy", 32'(busy), 32'd1);
        drain(0, 0, -1);

        // Backpressure: every beat stalled for 5 cycles.
        pulse_start();
        capture(20, DEPTH, 0, -1);
        drain(20, 5, -1);

        // Extra start pulses during CAPTURE and DRAIN, then re-arm from DONE.
        pulse_start();
        capture(40, DEPTH, 0, 3);
        drain(40, 2, 4);
        pulse_start();
        capture(100, DEPTH, 0, -1);
        drain(100, 0, -1);

        // Reset after 3 captured samples, then a full fresh run.
        pulse_start();
        capture(150, 3, 0, -1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_cnt", 32'(sample_cnt), 32'd0);
        chk("mid_rst_valid", 32'(m_valid), 32'd0);
        tick();
        pulse_start();
        capture(200, DEPTH, 0, -1);
        drain(200, 1, -1);

        // An edge coincident with start is not written, and a level held high writes once.
        data_in = 8'd55;
        dac_clk = 1'b1;
        start   = 1'b1;
        tick();
        start = 1'b0;
        chk("coinc_cnt", 32'(sample_cnt), 32'd0);
        chk("coinc_busy", 32'(busy), 32'd1);
        repeat (10) tick();
        chk("coinc_hold_cnt", 32'(sample_cnt), 32'd0);
        dac_clk = 1'b0;
        tick();
        data_in = 8'd60;
        dac_clk = 1'b1;
        repeat (50) tick();
        chk("held_cnt", 32'(sample_cnt), 32'd1);
        dac_clk = 1'b0;
        repeat (5) tick();
        capture(61, DEPTH - 1, 1, -1);
        drain(60, 0, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
